register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/rf_scoreboard.sv | 39 +++
 rtl/register_file_mp.sv | 113 +++++++++++
 tb/tb_register_file_mp.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the multi-ported register file: reset image and the hardwired-zero address.
package regfile_pkg;

    localparam int unsigned RF_IMG_DEPTH = 16;
    localparam int unsigned RF_ZERO_ADDR = 0;

    localparam logic [23:0] RF_RESET_IMAGE [RF_IMG_DEPTH] = '{
        24'h000000, 24'h001000, 24'h01CAC5, 24'h040000,
        24'h03858C, 24'h03EFFF, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    // Registers past the end of the image reset to zero.
    function automatic logic [23:0] rf_reset_word(input int idx);
        if (idx >= 0 && idx < int'(RF_IMG_DEPTH)) begin
            return RF_RESET_IMAGE[idx[3:0]];
        end
        return 24'h000000;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard: writes clear a register's busy bit, locks set it, lock wins a tie.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wa_vld,
    input  logic [ADDR_W-1:0]   i_wa_addr,
    input  logic                i_wb_vld,
    input  logic [ADDR_W-1:0]   i_wb_addr,
    input  logic                i_lock_vld,
    input  logic [ADDR_W-1:0]   i_lock_addr,
    output logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;

    always_comb begin
        w_busy_next = r_busy;
        if (i_wa_vld) w_busy_next[i_wa_addr] = 1'b0;
        if (i_wb_vld) w_busy_next[i_wb_addr] = 1'b0;
        if (i_lock_vld) w_busy_next[i_lock_addr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/register_file_mp.sv
// Multi-read, dual-write register file with hardwired-zero r0, optional write bypass,
// scoreboard busy tracking and a committed-write counter.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned BYPASS_EN = 1,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       lock_en,
    input  logic [ADDR_W-1:0]          lock_addr,
    output logic [NUM_REGS-1:0]        busy,
    output logic [15:0]                wr_count
);

    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [15:0]       r_wr_count;

    logic              w_wa_vld;
    logic              w_wb_vld;
    logic              w_lock_vld;
    logic [15:0]       w_count_inc;
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_lock_hit;

    assign w_wa_vld   = wa_en && (wa_addr != ZeroAddr);
    assign w_wb_vld   = wb_en && (wb_addr != ZeroAddr);
    assign w_lock_vld = lock_en && (lock_addr != ZeroAddr);

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wa_vld    (w_wa_vld),
        .i_wa_addr   (wa_addr),
        .i_wb_vld    (w_wb_vld),
        .i_wb_addr   (wb_addr),
        .i_lock_vld  (w_lock_vld),
        .i_lock_addr (lock_addr),
        .o_busy      (busy)
    );

    // A same-address collision commits a single write.
    always_comb begin
        w_count_inc = 16'd0;
        if (w_wa_vld && w_wb_vld && (wa_addr != wb_addr)) begin
            w_count_inc = 16'd2;
        end else if (w_wa_vld || w_wb_vld) begin
            w_count_inc = 16'd1;
        end
    end

    // Port B is applied last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= DATA_W'(rf_reset_word(i));
            end
            r_wr_count <= '0;
        end else begin
            if (w_wa_vld) r_regs[wa_addr] <= wa_data;
            if (w_wb_vld) r_regs[wb_addr] <= wb_data;
            r_wr_count <= r_wr_count + w_count_inc;
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_busy    = '0;
        w_ra       = '0;
        w_hit_a    = 1'b0;
        w_hit_b    = 1'b0;
        w_lock_hit = 1'b0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            w_ra       = rd_addr[k*ADDR_W +: ADDR_W];
            w_hit_a    = (BYPASS_EN != 0) && w_wa_vld && (wa_addr == w_ra);
            w_hit_b    = (BYPASS_EN != 0) && w_wb_vld && (wb_addr == w_ra);
            w_lock_hit = w_lock_vld && (lock_addr == w_ra);
            if (w_ra == ZeroAddr) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
            end else if (w_hit_b) begin
                rd_data[k*DATA_W +: DATA_W] = wb_data;
            end else if (w_hit_a) begin
                rd_data[k*DATA_W +: DATA_W] = wa_data;
            end else begin
                rd_data[k*DATA_W +: DATA_W] = r_regs[w_ra];
            end
            rd_busy[k] = busy[w_ra] && !((w_hit_a || w_hit_b) && !w_lock_hit);
        end
    end

    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_register_file_mp.sv
// Randomized and directed bench for register_file_mp against an array-based reference model.
module tb_register_file_mp;

    localparam int unsigned DW  = 24;
    localparam int unsigned NR  = 16;
    localparam int unsigned NRD = 2;
    localparam int unsigned AW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wa_en;
    logic [AW-1:0]     wa_addr;
    logic [DW-1:0]     wa_data;
    logic              wb_en;
    logic [AW-1:0]     wb_addr;
    logic [DW-1:0]     wb_data;
    logic              lock_en;
    logic [AW-1:0]     lock_addr;
    logic [NR-1:0]     busy;
    logic [15:0]       wr_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_busy;
    logic [15:0]   m_cnt;

    logic [DW-1:0] img [NR] = '{
        24'h000000, 24'h001000, 24'h01CAC5, 24'h040000,
        24'h03858C, 24'h03EFFF, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

    always #5 clk = ~clk;

    register_file_mp dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wa_en     (wa_en),
        .wa_addr   (wa_addr),
        .wa_data   (wa_data),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == a) return wb_data;
        if (wa_en && wa_addr == a) return wa_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (((wa_en && wa_addr == a) || (wb_en && wb_addr == a)) && !(lock_en && lock_addr == a))
            return 1'b0;
        return m_busy[a];
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < int'(NR); i++) m_regs[i] = img[i];
            m_busy = '0;
            m_cnt  = '0;
        end else begin
            int n;
            n = 0;
            if (wa_en && wa_addr != 0) begin
                m_regs[wa_addr] = wa_data;
                m_busy[wa_addr] = 1'b0;
                n++;
            end
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
                if (!(wa_en && wa_addr == wb_addr)) n++;
            end
            if (lock_en && lock_addr != 0) m_busy[lock_addr] = 1'b1;
            m_cnt = m_cnt + 16'(n);
        end
    endtask

    task automatic idle();
        rst     = 1'b0;
        wa_en   = 1'b0;
        wb_en   = 1'b0;
        lock_en = 1'b0;
    endtask

    // Advance one rising edge, update the model with the inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        wa_en = 1'b1; wa_addr = 4'd2; wa_data = 24'h123456;
        lock_en = 1'b1; lock_addr = 4'd4;
        tick();
        idle();
        rd_addr = {4'd5, 4'd2};
        #1;
        checks++;
        if (rd_data[23:0] !== 24'h01CAC5) begin
            failures++;
            $display("FAIL reset_r2 got=%h exp=%h", rd_data[23:0], 24'h01CAC5);
        end
        checks++;
        if (rd_data[47:24] !== 24'h03EFFF) begin
            failures++;
            $display("FAIL reset_r5 got=%h exp=%h", rd_data[47:24], 24'h03EFFF);
        end
        checks++;
        if (busy !== 16'h0000 || wr_count !== 16'h0000) begin
            failures++;
            $display("FAIL reset_state busy=%h wr_count=%h exp=0/0", busy, wr_count);
        end
        for (int i = 0; i < int'(NR); i++) begin
            rd_addr = {AW'(i), AW'(i)};
            #1;
            checks++;
            if (rd_data[23:0] !== img[i] || rd_busy !== 2'b00) begin
                failures++;
                $display("FAIL reset_image r%0d got=%h busy=%b exp=%h", i, rd_data[23:0],
                         rd_busy, img[i]);
            end
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 24'h0ABCDE;
        lock_en = 1'b1; lock_addr = 4'd0;
        rd_addr = {4'd0, 4'd0};
        #1;
        checks++;
        if (rd_data !== '0) begin
            failures++;
            $display("FAIL zero_bypass got=%h exp=0", rd_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data !== '0 || rd_busy !== 2'b00) begin
            failures++;
            $display("FAIL zero_read got=%h busy=%b exp=0", rd_data, rd_busy);
        end
        checks++;
        if (wr_count !== m_cnt || busy !== 16'h0000) begin
            failures++;
            $display("FAIL zero_count wr_count=%h busy=%h exp=%h/0", wr_count, busy, m_cnt);
        end
    endtask

    task automatic test_collision();
        logic [15:0] exp_cnt;
        idle();
        exp_cnt = m_cnt + 16'd1;
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 24'h111111;
        wb_en = 1'b1; wb_addr = 4'd3; wb_data = 24'h222222;
        rd_addr = {4'd2, 4'd3};
        #1;
        checks++;
        if (rd_data[23:0] !== 24'h222222) begin
            failures++;
            $display("FAIL collision_bypass got=%h exp=%h", rd_data[23:0], 24'h222222);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rd_data[23:0] !== 24'h222222) begin
            failures++;
            $display("FAIL collision_store got=%h exp=%h", rd_data[23:0], 24'h222222);
        end
        checks++;
        if (wr_count !== exp_cnt) begin
            failures++;
            $display("FAIL collision_count got=%h exp=%h", wr_count, exp_cnt);
        end
        exp_cnt = m_cnt + 16'd2;
        wa_en = 1'b1; wa_addr = 4'd7; wa_data = 24'h0A0A0A;
        wb_en = 1'b1; wb_addr = 4'd8; wb_data = 24'h0B0B0B;
        tick();
        idle();
        rd_addr = {4'd8, 4'd7};
        #1;
        checks++;
        if (wr_count !== exp_cnt || rd_data !== {24'h0B0B0B, 24'h0A0A0A}) begin
            failures++;
            $display("FAIL dual_write count=%h data=%h exp=%h/%h", wr_count, rd_data, exp_cnt,
                     {24'h0B0B0B, 24'h0A0A0A});
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rd_addr = {4'd0, 4'd6};
        lock_en = 1'b1; lock_addr = 4'd6;
        tick();
        idle();
        #1;
        checks++;
        if (busy[6] !== 1'b1 || rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL lock_set busy6=%b rd_busy=%b exp=1/1", busy[6], rd_busy[0]);
        end
        wa_en = 1'b1; wa_addr = 4'd6; wa_data = 24'h000042;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[23:0] !== 24'h000042) begin
            failures++;
            $display("FAIL write_bypass rd_busy=%b data=%h exp=0/000042", rd_busy[0],
                     rd_data[23:0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy[6] !== 1'b0) begin
            failures++;
            $display("FAIL write_clear busy6=%b exp=0", busy[6]);
        end
        wb_en = 1'b1; wb_addr = 4'd6; wb_data = 24'h000077;
        lock_en = 1'b1; lock_addr = 4'd6;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL lock_write_rdbusy got=%b exp=0", rd_busy[0]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy[6] !== 1'b1 || rd_data[23:0] !== 24'h000077) begin
            failures++;
            $display("FAIL lock_wins busy6=%b data=%h exp=1/000077", busy[6], rd_data[23:0]);
        end
        // Busy register written while already locked, with a new lock: busy read stays 1.
        wa_en = 1'b1; wa_addr = 4'd6; wa_data = 24'h000099;
        lock_en = 1'b1; lock_addr = 4'd6;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL relock_rdbusy got=%b exp=1", rd_busy[0]);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int it = 0; it < 400; it++) begin
            rst     = 1'b0;
            wa_en   = ($urandom_range(0, 2) != 0);
            wa_addr = AW'($urandom);
            wa_data = DW'($urandom);
            wb_en   = ($urandom_range(0, 2) != 0);
            wb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : AW'($urandom);
            wb_data = DW'($urandom);
            lock_en = ($urandom_range(0, 2) == 0);
            lock_addr = ($urandom_range(0, 3) == 0) ? wb_addr : AW'($urandom);
            rd_addr = NRD*AW'($urandom);
            if ($urandom_range(0, 2) == 0) rd_addr[3:0] = wa_addr;
            if ($urandom_range(0, 2) == 0) rd_addr[7:4] = wb_addr;
            #1;
            for (int k = 0; k < int'(NRD); k++) begin
                a = rd_addr[k*AW +: AW];
                checks++;
                if (rd_data[k*DW +: DW] !== exp_rd(a) || rd_busy[k] !== exp_rbusy(a)) begin
                    failures++;
                    $display("FAIL rand_read it=%0d port=%0d addr=%0d data=%h busy=%b exp=%h/%b",
                             it, k, a, rd_data[k*DW +: DW], rd_busy[k], exp_rd(a),
                             exp_rbusy(a));
                end
            end
            tick();
            checks++;
            if (busy !== m_busy || wr_count !== m_cnt) begin
                failures++;
                $display("FAIL rand_state it=%0d busy=%h wr_count=%h exp=%h/%h", it, busy,
                         wr_count, m_busy, m_cnt);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        idle();
        rst = 1'b1;
        tick();
        idle();
        wa_en = 1'b1; wa_addr = 4'd9;
        for (int i = 0; i < 65535; i++) begin
            wa_data = DW'(i);
            tick();
        end
        checks++;
        if (wr_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload got=%h exp=FFFF", wr_count);
        end
        tick();
        idle();
        checks++;
        if (wr_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_roll got=%h exp=0000", wr_count);
        end
    endtask

    task automatic test_midop_reset();
        idle();
        wa_en = 1'b1; wa_addr = 4'd1; wa_data = 24'h0ABCDE;
        lock_en = 1'b1; lock_addr = 4'd2;
        tick();
        idle();
        rst = 1'b1;
        wa_en = 1'b1; wa_addr = 4'd1; wa_data = 24'h00FFFF;
        wb_en = 1'b1; wb_addr = 4'd4; wb_data = 24'h055555;
        lock_en = 1'b1; lock_addr = 4'd1;
        tick();
        idle();
        rd_addr = {4'd4, 4'd1};
        #1;
        checks++;
        if (rd_data !== {24'h03858C, 24'h001000}) begin
            failures++;
            $display("FAIL midop_data got=%h exp=%h", rd_data, {24'h03858C, 24'h001000});
        end
        checks++;
        if (busy !== 16'h0000 || wr_count !== 16'h0000) begin
            failures++;
            $display("FAIL midop_state busy=%h wr_count=%h exp=0/0", busy, wr_count);
        end
    endtask

    initial begin
        idle();
        rd_addr   = '0;
        wa_addr   = '0;
        wa_data   = '0;
        wb_addr   = '0;
        wb_data   = '0;
        lock_addr = '0;
        m_busy    = '0;
        m_cnt     = '0;
        for (int i = 0; i < int'(NR); i++) m_regs[i] = '0;
        #2;
        test_reset();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_random();
        test_midop_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
